// File: rtl/cordic_iter.sv
// Iterative CORDIC: sin/cos by rotation, arctan/hypot by vectoring.
// One micro-rotation per cycle; angles are in degrees, fixed point.
module cordic_iter #(
  parameter int W     = 16,
  parameter int FRAC  = 8,
  parameter int ITER  = 12,
  parameter int GUARD = 2
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [1:0]          op,
  input  logic signed [W-1:0] angle_in,
  input  logic signed [W-1:0] x_in,
  input  logic signed [W-1:0] y_in,
  output logic                out_valid,
  input  logic                out_ready,
  output logic signed [W-1:0] out_data,
  output logic                out_err
);

  localparam int WD = W + GUARD;
  localparam int IW = $clog2(ITER + 1);
  localparam int TN = 2 ** IW;
  localparam real PI = 3.141592653589793;
  localparam int LIM = 90 * (2 ** FRAC);

  function automatic real k_gain();
    real k;
    k = 1.0;
    for (int n = 0; n < ITER; n++)
      k = k / $sqrt(1.0 + 1.0 / (4.0 ** n));
    return k;
  endfunction

  localparam int K_FIX = $rtoi(k_gain() * (2.0 ** FRAC) + 0.5);

  localparam logic signed [WD-1:0] SMAX =
    WD'((64'sd1 <<< (W - 1)) - 64'sd1);
  localparam logic signed [WD-1:0] SMIN = -SMAX - WD'(1);

  logic signed [WD-1:0] atan_tab [TN];

  for (genvar g = 0; g < TN; g++) begin : g_atan
    localparam real AR =
      $atan(1.0 / (2.0 ** g)) * 180.0 / PI * (2.0 ** FRAC);
    localparam int AI = $rtoi(AR + 0.5);
    assign atan_tab[g] = WD'(AI);
  end

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  state_t state, state_n;

  logic signed [WD-1:0] x, y, z;
  logic signed [WD-1:0] xs, ys, x_n, y_n, z_n;
  logic signed [WD-1:0] sel;
  logic signed [W-1:0]  sat;
  logic [IW-1:0]        i;
  logic [1:0]           op_q;
  logic                 err_q, zero_q, dpos;
  logic                 last, bad_in;

  assign last = (i == IW'(ITER));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_n;
  end

  always_comb begin
    state_n   = state;
    in_ready  = 1'b0;
    out_valid = 1'b0;
    unique case (state)
      IDLE: begin
        in_ready = ~rst;
        if (in_valid) state_n = RUN;
      end
      RUN: begin
        if (last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  // Rotation steers z to zero, vectoring steers y to zero.
  always_comb begin
    dpos = op_q[1] ? y[WD-1] : ~z[WD-1];
    xs   = x >>> i;
    ys   = y >>> i;
    x_n  = dpos ? x - ys : x + ys;
    y_n  = dpos ? y + xs : y - xs;
    z_n  = dpos ? z - atan_tab[i] : z + atan_tab[i];
  end

  always_comb begin
    unique case (op_q)
      2'b00:   sel = y;
      2'b10:   sel = z;
      default: sel = x;
    endcase
    if (sel > SMAX)      sat = SMAX[W-1:0];
    else if (sel < SMIN) sat = SMIN[W-1:0];
    else                 sat = sel[W-1:0];
  end

  assign bad_in = op[1] ? x_in[W-1]
                        : (int'(angle_in) > LIM ||
                           int'(angle_in) < -LIM);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x        <= '0;
      y        <= '0;
      z        <= '0;
      i        <= '0;
      op_q     <= '0;
      err_q    <= 1'b0;
      zero_q   <= 1'b0;
      out_data <= '0;
      out_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (in_valid) begin
            op_q   <= op;
            i      <= '0;
            err_q  <= bad_in;
            zero_q <= (x_in == '0) && (y_in == '0);
            if (op[1]) begin
              x <= WD'(x_in);
              y <= WD'(y_in);
              z <= '0;
            end else begin
              x <= WD'(K_FIX);
              y <= '0;
              z <= WD'(angle_in);
            end
          end
        end
        RUN: begin
          if (last) begin
            // Zero vector has no defined angle; report 0.
            if (err_q || (op_q[1] && zero_q))
              out_data <= '0;
            else
              out_data <= sat;
            out_err <= err_q;
          end else begin
            x <= x_n;
            y <= y_n;
            z <= z_n;
            i <= i + IW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_cordic_iter.sv
// Directed bench for cordic_iter: functions, errors,
// backpressure and reset during an operation.
module tb_cordic_iter;

  localparam int W = 16;

  logic                clk = 1'b0;
  logic                rst;
  logic                in_valid;
  logic                in_ready;
  logic [1:0]          op;
  logic signed [W-1:0] angle_in;
  logic signed [W-1:0] x_in;
  logic signed [W-1:0] y_in;
  logic                out_valid;
  logic                out_ready;
  logic signed [W-1:0] out_data;
  logic                out_err;

  int passed = 0;
  int total  = 0;

  always #5 clk = ~clk;

  cordic_iter #(
    .W(16), .FRAC(8), .ITER(12), .GUARD(2)
  ) dut (
    .clk(clk),
    .rst(rst),
    .in_valid(in_valid),
    .in_ready(in_ready),
    .op(op),
    .angle_in(angle_in),
    .x_in(x_in),
    .y_in(y_in),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .out_data(out_data),
    .out_err(out_err)
  );

  task automatic chk(input string tag, input int obs,
                     input int exp);
    total = total + 1;
    assert (obs === exp) passed = passed + 1;
    else $error("FAIL %s observed=%0d expected=%0d",
                tag, obs, exp);
  endtask

  task automatic chk_tol(input string tag, input int obs,
                         input int exp, input int tol);
    total = total + 1;
    assert ((obs >= exp - tol && obs <= exp + tol) === 1'b1)
      passed = passed + 1;
    else $error("FAIL %s observed=%0d expected=%0d+-%0d",
                tag, obs, exp, tol);
  endtask

  task automatic start(input string tag, input logic [1:0] o,
                       input int a, input int x, input int y);
    @(negedge clk);
    op       = o;
    angle_in = W'(a);
    x_in     = W'(x);
    y_in     = W'(y);
    in_valid = 1'b1;
    chk({tag, "_ready"}, int'(in_ready), 1);
    @(posedge clk);
    #1 in_valid = 1'b0;
  endtask

  task automatic wait_valid(output int cyc);
    cyc = 0;
    for (int c = 1; c <= 40; c++) begin
      @(posedge clk);
      #1;
      if (out_valid) begin
        cyc = c;
        break;
      end
    end
  endtask

  task automatic release_out(input string tag);
    @(negedge clk);
    out_ready = 1'b1;
    @(posedge clk);
    #1 out_ready = 1'b0;
    chk({tag, "_vld_drop"}, int'(out_valid), 0);
    chk({tag, "_rdy_back"}, int'(in_ready), 1);
  endtask

  task automatic run(input string tag, input logic [1:0] o,
                     input int a, input int x, input int y,
                     input int exp, input int tol,
                     input int eerr);
    int cyc;
    start(tag, o, a, x, y);
    wait_valid(cyc);
    chk({tag, "_lat"}, cyc, 13);
    chk_tol({tag, "_data"}, int'(out_data), exp, tol);
    chk({tag, "_err"}, int'(out_err), eerr);
    chk({tag, "_busy"}, int'(in_ready), 0);
    release_out(tag);
  endtask

  initial begin
    int cyc;
    int bad;
    rst       = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    op        = '0;
    angle_in  = '0;
    x_in      = '0;
    y_in      = '0;
    #1 rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    chk("rst_in_ready", int'(in_ready), 0);
    chk("rst_out_valid", int'(out_valid), 0);
    chk("rst_out_data", int'(out_data), 0);
    chk("rst_out_err", int'(out_err), 0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1 chk("post_rst_ready", int'(in_ready), 1);

    run("sin30", 2'b00, 7680, 0, 0, 128, 3, 0);
    run("cos60", 2'b01, 15360, 0, 0, 128, 3, 0);
    run("cos0", 2'b01, 0, 0, 0, 256, 3, 0);
    run("sinm90", 2'b00, -23040, 0, 0, -256, 3, 0);
    run("atan45", 2'b10, 0, 256, 256, 11520, 8, 0);
    run("hypot", 2'b11, 0, 256, 256, 596, 4, 0);
    run("err91", 2'b00, 23296, 0, 0, 0, 0, 1);
    run("err_xneg", 2'b10, 0, -1, 0, 0, 0, 1);
    run("zero_vec", 2'b10, 0, 0, 0, 0, 0, 0);

    // Backpressure: result must hold while extra requests are ignored.
    start("bp", 2'b00, 7680, 0, 0);
    wait_valid(cyc);
    chk("bp_lat", cyc, 13);
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      in_valid = 1'b1;
      op       = 2'b01;
      angle_in = 16'sd0;
      @(posedge clk);
      #1;
      if (!out_valid || in_ready || out_err ||
          out_data < 125 || out_data > 131)
        bad = bad + 1;
    end
    chk("bp_hold", bad, 0);
    chk_tol("bp_data", int'(out_data), 128, 3);
    @(negedge clk);
    in_valid = 1'b0;
    release_out("bp");
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid || !in_ready) bad = bad + 1;
    end
    chk("bp_not_queued", bad, 0);

    // Reset while the rotation counter is at 5.
    start("mid", 2'b01, 0, 0, 0);
    repeat (5) @(posedge clk);
    #2 rst = 1'b1;
    #1;
    chk("mid_in_ready", int'(in_ready), 0);
    chk("mid_out_valid", int'(out_valid), 0);
    chk("mid_out_data", int'(out_data), 0);
    chk("mid_out_err", int'(out_err), 0);
    @(negedge clk);
    rst = 1'b0;
    bad = 0;
    for (int k = 0; k < 20; k++) begin
      @(posedge clk);
      #1;
      if (out_valid) bad = bad + 1;
    end
    chk("mid_no_stale", bad, 0);
    run("fresh", 2'b01, 15360, 0, 0, 128, 3, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/cordic_iter.md
CORDIC_ITER -- requirements
Module: cordic_iter

Interface
REQ-001 SHALL provide parameter W, default 16, meaning I/O data width (two's complement).
REQ-002 SHALL provide parameter FRAC, default 8, meaning number of fractional bits in all data and angle ports.
REQ-003 SHALL provide parameter ITER, default 12 (legal range 4..W), meaning number of micro-rotations per operation.
REQ-004 SHALL provide parameter GUARD, default 2, meaning extra MSBs in the internal x/y/z datapath.
REQ-005 clk  in  1  single clock; all state changes on its rising edge.
REQ-006 rst  in  1  reset, asynchronous assert, active-high.
REQ-007 in_valid  in  1  request present.
REQ-008 in_ready  out  1  block can accept a request.
REQ-009 op  in  2  00 sin, 01 cos, 10 arctan(y/x), 11 hypot (gain-uncompensated).
REQ-010 angle_in  in  W  rotation angle, degrees, signed Q(W-FRAC).FRAC.
REQ-011 x_in  in  W  vectoring x, signed QFRAC.
REQ-012 y_in  in  W  vectoring y, signed QFRAC.
REQ-013 out_valid  out  1  result held on out_data.
REQ-014 out_ready  in  1  consumer accepts the result.
REQ-015 out_data  out  W  result, signed QFRAC; angles in degrees QFRAC.
REQ-016 out_err  out  1  qualifies out_data; request was out of range.

Function
REQ-017 States: IDLE, RUN, DONE; in_ready = 1 only in IDLE.
REQ-018 IDLE->RUN on in_valid & in_ready; op, angle_in, x_in and y_in captured that edge; counter i cleared to 0.
REQ-019 RUN: one micro-rotation per cycle, i = 0..ITER-1; x' = x - d*(y>>>i), y' = y + d*(x>>>i), z' = z - d*atan_tab[i].
REQ-020 Direction: rotation (op 0x) d = +1 if z >= 0, else -1; vectoring (op 1x) d = +1 if y < 0, else -1.
REQ-021 atan_tab[i] = round(atan(2^-i) in degrees × 2^FRAC), generated at elaboration for any ITER; no hand-typed table.
REQ-022 Rotation init: x = round(K × 2^FRAC) with K = prod(1/sqrt(1+2^-2i)) over ITER (155 at FRAC=8, ITER=12); y = 0; z = angle_in.
REQ-023 Vectoring init: x = x_in, y = y_in, z = 0.
REQ-024 Internal x/y/z width is W+GUARD; all shifts are arithmetic.
REQ-025 RUN->DONE after micro-rotation ITER-1; op 00 -> y, 01 -> x, 10 -> z, 11 -> x (magnitude × 1/K gain, uncompensated).
REQ-026 Result SHALL saturate to W bits: max 2^(W-1)-1, min -2^(W-1); no wrap.
REQ-027 Latency: accept edge at cycle 0, out_valid asserted at cycle ITER+1 (13 at default).
REQ-028 DONE: out_valid = 1; out_data and out_err stable until out_valid & out_ready.
REQ-029 DONE->IDLE on out_ready; in_ready rises the next cycle, so there is no same-cycle accept (1 bubble).
REQ-030 out_ready asserted before DONE has no effect; in_valid outside IDLE is ignored and not queued.
REQ-031 out_err = 1 for rotation with |angle_in| > 90°, or vectoring with x_in < 0; the state sequence and latency are unchanged, and out_data = 0.
REQ-032 Vectoring with x_in = y_in = 0: out_data = 0, out_err = 0.

Reset
REQ-033 rst asserted at any time: state -> IDLE, out_valid = 0, out_err = 0, out_data = 0, i = 0, in_ready = 0 while rst is high.
REQ-034 in_ready = 1 from the first clock edge after rst deasserts.
REQ-035 An operation in flight at reset is discarded; no out_valid is produced for it.

Verification
REQ-036 Rotation, op=00, angle_in=7680 (30°) -> out_data 128 ±3, out_err=0, out_valid at cycle 13.
REQ-037 Rotation, op=01, angle_in=15360 (60°) -> 128 ±3; op=01 angle_in=0 -> 256 ±3; op=00 angle_in=-23040 (-90°) -> -256 ±3.
REQ-038 Vectoring, op=10, x_in=y_in=256 -> 11520 (45°) ±8; op=11 same inputs -> round(362×1.6468) = 596 ±4.
REQ-039 Errors: op=00 angle_in=23296 (91°) -> out_err=1, out_data=0; op=10 x_in=-1 -> out_err=1; op=10 x_in=y_in=0 -> 0, out_err=0.
REQ-040 Backpressure: out_ready held low 20 cycles -> out_valid and out_data stable, in_ready=0, extra in_valid ignored; release -> one accept, in_ready=1 next cycle.
REQ-041 Reset mid-RUN at i=5 -> all outputs cleared within the same cycle, no stale out_valid; a fresh request after release completes at correct latency with the correct value.
